// File: rtl/median_ctrl_pkg.sv
// Shared types and constants for the median-filter frame controllers.
// Holds the sequencer state encoding, kernel geometry and a coordinate
// width helper that the 3x3/5x5/7x7 variants all use.
package median_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } ctrl_state_e;

   localparam int unsigned KSIZE = 7;
   localparam int unsigned KHALF = 3;

   // Bits needed to hold a coordinate in [0, n-1]; never narrower than 1.
   function automatic int unsigned coord_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/median_credit_cnt.sv
// Up/down saturating counter with simultaneous increment/decrement.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (loads INIT_VAL)
//   inc_i      : count up by one
//   dec_i      : count down by one (inc_i && dec_i leaves the count unchanged)
//   cnt_o      : current count, registered
//   err_c_o    : combinational; an inc at MAX_VAL or a dec at 0 was ignored
module median_credit_cnt #(
   parameter int unsigned MAX_VAL  = 16,
   parameter int unsigned INIT_VAL = 16,
   localparam int unsigned CNT_W   = $clog2(MAX_VAL + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             err_c_o
);

   localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_VAL);
   localparam logic [CNT_W-1:0] INIT_C = CNT_W'(INIT_VAL);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count; an out-of-range step is dropped and flagged.
   always_comb begin
      cnt_d   = cnt_q;
      err_c_o = 1'b0;
      if (inc_i && !dec_i) begin
         if (cnt_q == MAX_C) begin
            err_c_o = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (dec_i && !inc_i) begin
         if (cnt_q == '0) begin
            err_c_o = 1'b1;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= INIT_C;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/median7_frame_ctrl.sv
// Frame sequencer for the 7x7 median datapath: counts raster pixels, issues
// a window to the sorter for every pixel that completes a 7x7 neighbourhood,
// and holds off input when downstream result storage has no free entry.
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   in_valid/in_sof       : pixel beat and first-pixel-of-frame qualifier
//   in_ready              : combinational accept (state and credits only)
//   win_valid/row/col     : registered window issue pulse and centre coordinate
//   res_done              : one result left the sorter
//   fifo_pop              : downstream freed one result entry
//   busy                  : sequencer not idle
//   frame_done            : one-cycle pulse once the last result has returned
//   err_sof, err_ovf      : sticky protocol errors, cleared only by reset
module median7_frame_ctrl
   import median_ctrl_pkg::*;
#(
   parameter int unsigned IMG_W        = 640,
   parameter int unsigned IMG_H        = 480,
   parameter int unsigned OUT_DEPTH    = 16,
   parameter int unsigned MAX_INFLIGHT = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic                        in_sof,
   output logic                        in_ready,
   output logic                        win_valid,
   output logic [coord_w(IMG_H)-1:0]   win_row,
   output logic [coord_w(IMG_W)-1:0]   win_col,
   input  logic                        res_done,
   input  logic                        fifo_pop,
   output logic                        busy,
   output logic                        frame_done,
   output logic                        err_sof,
   output logic                        err_ovf
);

   localparam int unsigned ROW_W  = coord_w(IMG_H);
   localparam int unsigned COL_W  = coord_w(IMG_W);
   localparam int unsigned CRED_W = $clog2(OUT_DEPTH + 1);
   localparam int unsigned INFL_W = $clog2(MAX_INFLIGHT + 1);

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] WIN_ROW0 = ROW_W'(KSIZE - 1);
   localparam logic [COL_W-1:0] WIN_COL0 = COL_W'(KSIZE - 1);

   ctrl_state_e       state_q, state_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic              win_valid_q;
   logic [ROW_W-1:0]  win_row_q;
   logic [COL_W-1:0]  win_col_q;
   logic              frame_done_q;
   logic              err_sof_q;
   logic              err_ovf_q;

   logic              accept_c;
   logic              win_hit_c;
   logic              sof_err_c;
   logic              frame_end_c;

   logic [CRED_W-1:0] credits;
   logic [INFL_W-1:0] inflight;
   logic              cred_err_c;
   logic              infl_err_c;

   // Output-buffer credits: one consumed per issued window, returned per pop.
   median_credit_cnt #(
      .MAX_VAL  (OUT_DEPTH),
      .INIT_VAL (OUT_DEPTH)
   ) u_credits (
      .clk     (clk),
      .rst_n   (rst),
      .inc_i   (fifo_pop),
      .dec_i   (win_hit_c),
      .cnt_o   (credits),
      .err_c_o (cred_err_c)
   );

   // Results inside the sorter pipeline.
   median_credit_cnt #(
      .MAX_VAL  (MAX_INFLIGHT),
      .INIT_VAL (0)
   ) u_inflight (
      .clk     (clk),
      .rst_n   (rst),
      .inc_i   (win_valid_q),
      .dec_i   (res_done),
      .cnt_o   (inflight),
      .err_c_o (infl_err_c)
   );

   // Gated by rst so the stream is never acknowledged while held in reset.
   assign in_ready = rst && (credits != '0) && ((state_q == IDLE) || (state_q == RUN));
   assign accept_c = in_valid && in_ready;

   // Next-state, raster position and window decode.
   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      win_hit_c   = 1'b0;
      sof_err_c   = 1'b0;
      frame_end_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Beats before start-of-frame are swallowed; the sof beat is (0,0).
            if (accept_c && in_sof) begin
               state_d = RUN;
               row_d   = '0;
               col_d   = COL_W'(1);
            end
         end
         RUN: begin
            if (accept_c) begin
               if (in_sof) begin
                  sof_err_c = 1'b1;
                  row_d     = '0;
                  col_d     = COL_W'(1);
               end else begin
                  win_hit_c = (row_q >= WIN_ROW0) && (col_q >= WIN_COL0);
                  if (col_q == LAST_COL) begin
                     col_d = '0;
                     if (row_q == LAST_ROW) begin
                        state_d = DRAIN;
                     end else begin
                        row_d = row_q + ROW_W'(1);
                     end
                  end else begin
                     col_d = col_q + COL_W'(1);
                  end
               end
            end
         end
         DRAIN: begin
            // A window issued on the final pixel is still in win_valid_q.
            if ((inflight == '0) && !win_valid_q) begin
               state_d     = DONE;
               frame_end_c = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         row_q        <= '0;
         col_q        <= '0;
         win_valid_q  <= 1'b0;
         win_row_q    <= '0;
         win_col_q    <= '0;
         frame_done_q <= 1'b0;
         err_sof_q    <= 1'b0;
         err_ovf_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         col_q        <= col_d;
         win_valid_q  <= win_hit_c;
         frame_done_q <= frame_end_c;
         if (win_hit_c) begin
            win_row_q <= row_q - ROW_W'(KHALF);
            win_col_q <= col_q - COL_W'(KHALF);
         end
         if (sof_err_c) begin
            err_sof_q <= 1'b1;
         end
         if (cred_err_c || infl_err_c) begin
            err_ovf_q <= 1'b1;
         end
      end
   end

   assign win_valid  = win_valid_q;
   assign win_row    = win_row_q;
   assign win_col    = win_col_q;
   assign busy       = (state_q != IDLE);
   assign frame_done = frame_done_q;
   assign err_sof    = err_sof_q;
   assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_median7_frame_ctrl.sv
// Directed bench for median7_frame_ctrl on a 10x8 frame: instance A has 16
// result credits, instance B has 4 so credit exhaustion is reachable.
module tb_median7_frame_ctrl;

   localparam int unsigned W  = 10;
   localparam int unsigned H  = 8;
   localparam int unsigned RW = 3;
   localparam int unsigned CW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic          a_rst, a_in_valid, a_in_sof, a_in_ready, a_win_valid;
   logic [RW-1:0] a_win_row;
   logic [CW-1:0] a_win_col;
   logic          a_res_done, a_fifo_pop, a_busy, a_frame_done, a_err_sof, a_err_ovf;
   logic          b_rst, b_in_valid, b_in_sof, b_in_ready, b_win_valid;
   logic [RW-1:0] b_win_row;
   logic [CW-1:0] b_win_col;
   logic          b_res_done, b_fifo_pop, b_busy, b_frame_done, b_err_sof, b_err_ovf;

   logic          a_auto, a_res_man, a_pop_man, b_pop_man;
   logic [15:0]   a_dl, b_dl;

   // Sorter model: result 12 cycles after issue; A's downstream pops 2 later.
   assign a_res_done = (a_auto & a_dl[12]) | a_res_man;
   assign a_fifo_pop = (a_auto & a_dl[14]) | a_pop_man;
   assign b_res_done = b_dl[12];
   assign b_fifo_pop = b_pop_man;

   median7_frame_ctrl #(.IMG_W(W), .IMG_H(H), .OUT_DEPTH(16), .MAX_INFLIGHT(32)) u_a (
      .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_sof(a_in_sof),
      .in_ready(a_in_ready), .win_valid(a_win_valid), .win_row(a_win_row),
      .win_col(a_win_col), .res_done(a_res_done), .fifo_pop(a_fifo_pop),
      .busy(a_busy), .frame_done(a_frame_done), .err_sof(a_err_sof), .err_ovf(a_err_ovf)
   );

   median7_frame_ctrl #(.IMG_W(W), .IMG_H(H), .OUT_DEPTH(4), .MAX_INFLIGHT(32)) u_b (
      .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_sof(b_in_sof),
      .in_ready(b_in_ready), .win_valid(b_win_valid), .win_row(b_win_row),
      .win_col(b_win_col), .res_done(b_res_done), .fifo_pop(b_fifo_pop),
      .busy(b_busy), .frame_done(b_frame_done), .err_sof(b_err_sof), .err_ovf(b_err_ovf)
   );

   logic [6:0] a_wq[$];
   logic [6:0] b_wq[$];
   int a_fd = 0;
   int b_fd = 0;

   // Delay lines and window/frame_done recorders, all on the falling edge.
   initial begin
      a_dl = '0;
      b_dl = '0;
      forever begin
         @(negedge clk);
         a_dl = {a_dl[14:0], a_win_valid};
         b_dl = {b_dl[14:0], b_win_valid};
         if (a_win_valid === 1'b1) a_wq.push_back({a_win_row, a_win_col});
         if (b_win_valid === 1'b1) b_wq.push_back({b_win_row, b_win_col});
         if (a_frame_done === 1'b1) a_fd++;
         if (b_frame_done === 1'b1) b_fd++;
      end
   end

   int a_beats = 0;
   int b_beats = 0;
   int a_sof2  = -1;
   int q0 = 0;
   int f0 = 0;
   int g  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic a_step();
      a_in_valid = 1'b1;
      a_in_sof   = (a_beats == 0) || (a_beats == a_sof2);
      if (a_in_ready === 1'b1) a_beats++;
      @(negedge clk);
   endtask

   task automatic a_run(input int n);
      int lim = 0;
      while (a_beats < n && lim < 1000) begin
         a_step();
         lim++;
      end
      a_in_valid = 1'b0;
      a_in_sof   = 1'b0;
      chk("a_stream_beats", a_beats, n);
   endtask

   task automatic a_wait_done(input string tag);
      int lim = 0;
      while (a_frame_done !== 1'b1 && lim < 200) begin
         @(negedge clk);
         lim++;
      end
      chk(tag, a_frame_done, 1);
      idle(5);
   endtask

   task automatic b_step(input logic pop);
      b_pop_man  = pop;
      b_in_valid = 1'b1;
      b_in_sof   = (b_beats == 0);
      if (b_in_ready === 1'b1) b_beats++;
      @(negedge clk);
      b_pop_man = 1'b0;
   endtask

   initial begin
      a_rst = 1'b0; b_rst = 1'b0;
      a_in_valid = 1'b0; a_in_sof = 1'b0; b_in_valid = 1'b0; b_in_sof = 1'b0;
      a_auto = 1'b1; a_res_man = 1'b0; a_pop_man = 1'b0; b_pop_man = 1'b0;
      idle(2);

      // Reset values while held in reset
      chk("rst_a_in_ready", a_in_ready, 0);
      chk("rst_a_busy", a_busy, 0);
      chk("rst_a_win_valid", a_win_valid, 0);
      chk("rst_a_frame_done", a_frame_done, 0);
      chk("rst_a_err_sof", a_err_sof, 0);
      chk("rst_a_err_ovf", a_err_ovf, 0);
      chk("rst_b_in_ready", b_in_ready, 0);
      a_rst = 1'b1; b_rst = 1'b1;
      @(negedge clk);
      chk("idle_a_in_ready", a_in_ready, 1);
      chk("idle_a_busy", a_busy, 0);

      // Full frame, continuous valid, every result popped
      q0 = a_wq.size(); f0 = a_fd; a_beats = 0;
      a_run(80);
      chk("t1_busy_in_drain", a_busy, 1);
      a_wait_done("t1_frame_done");
      chk("t1_nwin", a_wq.size() - q0, 8);
      chk("t1_first_ctr", a_wq[q0], {3'd3, 4'd3});
      chk("t1_second_ctr", a_wq[q0+1], {3'd3, 4'd4});
      chk("t1_fifth_ctr", a_wq[q0+4], {3'd4, 4'd3});
      chk("t1_last_ctr", a_wq[q0+7], {3'd4, 4'd6});
      chk("t1_nframe_done", a_fd - f0, 1);
      chk("t1_busy_after", a_busy, 0);
      chk("t1_err_sof", a_err_sof, 0);
      chk("t1_err_ovf", a_err_ovf, 0);
      idle(20);

      // Mid-frame sof at beat 30 restarts at (0,0)
      q0 = a_wq.size(); f0 = a_fd; a_beats = 0; a_sof2 = 30;
      a_run(30);
      chk("t4_err_sof_before", a_err_sof, 0);
      a_run(110);
      chk("t4_err_sof_after", a_err_sof, 1);
      a_wait_done("t4_frame_done");
      a_sof2 = -1;
      chk("t4_nwin", a_wq.size() - q0, 8);
      chk("t4_first_ctr", a_wq[q0], {3'd3, 4'd3});
      chk("t4_last_ctr", a_wq[q0+7], {3'd4, 4'd6});
      chk("t4_nframe_done", a_fd - f0, 1);
      idle(20);

      // Reset while draining with 5 results outstanding
      a_auto = 1'b0;
      q0 = a_wq.size(); f0 = a_fd; a_beats = 0;
      a_run(80);
      idle(4);
      chk("t5_nwin", a_wq.size() - q0, 8);
      a_res_man = 1'b1;
      idle(3);
      a_res_man = 1'b0;
      idle(3);
      chk("t5_busy_inflight5", a_busy, 1);
      chk("t5_no_done_yet", a_fd - f0, 0);
      a_rst = 1'b0;
      #1;
      chk("t5_rst_busy", a_busy, 0);
      chk("t5_rst_in_ready", a_in_ready, 0);
      chk("t5_rst_win_valid", a_win_valid, 0);
      chk("t5_rst_frame_done", a_frame_done, 0);
      chk("t5_rst_err_sof", a_err_sof, 0);
      @(negedge clk);
      a_rst = 1'b1;
      idle(20);
      chk("t5_post_busy", a_busy, 0);
      chk("t5_post_in_ready", a_in_ready, 1);
      chk("t5_post_no_done", a_fd - f0, 0);

      // Pop with credits full (also proves credits reloaded to 16)
      chk("t6_err_ovf_clear", a_err_ovf, 0);
      a_pop_man = 1'b1;
      @(negedge clk);
      a_pop_man = 1'b0;
      chk("t6_pop_full_err", a_err_ovf, 1);
      a_rst = 1'b0;
      @(negedge clk);
      a_rst = 1'b1;
      @(negedge clk);
      chk("t6_err_ovf_rst", a_err_ovf, 0);
      a_res_man = 1'b1;
      @(negedge clk);
      a_res_man = 1'b0;
      chk("t6_res_at_zero_err", a_err_ovf, 1);
      // inflight must still be 0 or the next frame never completes
      a_auto = 1'b1;
      q0 = a_wq.size(); a_beats = 0;
      a_run(80);
      a_wait_done("t6_frame_after_underflow");
      chk("t6_nwin", a_wq.size() - q0, 8);

      // Instance B: illegal pop at full, then credit exhaustion
      b_pop_man = 1'b1;
      @(negedge clk);
      b_pop_man = 1'b0;
      chk("b_pop_full_err", b_err_ovf, 1);
      b_beats = 0;
      g = 0;
      while (b_beats < 70 && g < 500) begin
         b_step(1'b0);
         g++;
      end
      chk("b_beats_at_4th_win", b_beats, 70);
      chk("b_ready_fall", b_in_ready, 0);
      repeat (3) b_step(1'b0);
      chk("b_stalled_beats", b_beats, 70);
      chk("b_nwin_4", b_wq.size(), 4);
      b_step(1'b1);
      g = 0;
      while (b_in_ready === 1'b1 && g < 50) begin
         b_step(1'b0);
         g++;
      end
      chk("b_beats_one_more_win", b_beats, 77);
      repeat (2) b_step(1'b0);
      chk("b_nwin_5", b_wq.size(), 5);
      chk("b_ready_again_0", b_in_ready, 0);

      // credits=1: window accept and pop in the same cycle
      b_step(1'b1);
      chk("b_cred1_ready", b_in_ready, 1);
      b_step(1'b1);
      chk("b_same_cycle_beats", b_beats, 78);
      chk("b_same_cycle_ready", b_in_ready, 1);
      b_step(1'b0);
      chk("b_after_last_credit_beats", b_beats, 79);
      chk("b_after_last_credit_ready", b_in_ready, 0);
      b_step(1'b1);
      b_step(1'b0);
      b_in_valid = 1'b0;
      b_in_sof   = 1'b0;
      chk("b_final_beats", b_beats, 80);
      g = 0;
      while (b_frame_done !== 1'b1 && g < 200) begin
         @(negedge clk);
         g++;
      end
      chk("b_frame_done", b_frame_done, 1);
      idle(5);
      chk("b_nwin_8", b_wq.size(), 8);
      chk("b_last_ctr", b_wq[7], {3'd4, 4'd6});
      chk("b_nframe_done", b_fd, 1);
      chk("b_busy_after", b_busy, 0);
      chk("b_err_sof", b_err_sof, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/median7_frame_ctrl.md
# median7_frame_ctrl

Frame-level sequencer for the 7x7 median-filter datapath. It counts the incoming raster pixel stream, flags each cycle where a complete 7x7 window is present, and issues that window to the pipelined sorter. It tracks in-flight results and output-buffer credits so the stall-free sorter pipeline never overruns downstream storage. It signals end-of-frame only after the last result has returned.

## Interface
- IMG_W, 640: pixels per line (≥7)
- IMG_H, 480: lines per frame (≥7)
- OUT_DEPTH, 16: result-buffer entries downstream (credits); ≥1
- MAX_INFLIGHT, 32: in-flight counter capacity; ≥ sorter latency + 1
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  pixel present on stream
- in_sof  in  1  qualifies first pixel of frame (valid with in_valid)
- in_ready  out  1  pixel accepted when in_valid && in_ready
- win_valid  out  1  window issue pulse to line-buffer/sorter (drives its done_i)
- win_row  out  $clog2(IMG_H)  centre row of issued window
- win_col  out  $clog2(IMG_W)  centre column of issued window
- res_done  in  1  sorter done_o: one result leaves pipeline
- fifo_pop  in  1  downstream consumed one result entry (returns a credit)
- busy  out  1  state ≠ IDLE
- frame_done  out  1  one-cycle pulse, frame fully processed
- err_sof  out  1  sticky: in_sof seen mid-frame
- err_ovf  out  1  sticky: fifo_pop with credits == OUT_DEPTH, or res_done with inflight == 0

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready = (credits ≠ 0). A beat without in_sof is accepted and discarded. A beat with in_sof enters RUN and is counted as pixel (0,0).
- RUN: each accepted beat advances col. Col wraps at IMG_W-1 to 0 and increments row.
  - Window valid iff row ≥ 6 and col ≥ 6.
  - Centre = (row-3, col-3). Valid-only filtering, no padding.
  - Output count per frame: (IMG_W-6)·(IMG_H-6).
- Acceptance of pixel (IMG_H-1, IMG_W-1) moves RUN to DRAIN.
- DRAIN: in_ready = 0. Stay until inflight == 0 and no win_valid is pending, then go to DONE.
- DONE: frame_done = 1 for one cycle, then IDLE.
- in_sof accepted in RUN (not at pixel 0,0): set err_sof, restart counters at (0,0), stay in RUN. In-flight tracking continues unaffected.
- Credits (reset OUT_DEPTH):
  - Decrement on accepting a window-valid pixel; increment on fifo_pop.
  - Both in the same cycle: unchanged.
  - Illegal pop at OUT_DEPTH: ignored, err_ovf set.
- in_ready in RUN = (credits ≠ 0). Conservative: this also stalls non-window pixels.
- inflight (reset 0):
  - Increment on win_valid, decrement on res_done; both in the same cycle: unchanged.
  - res_done at inflight 0: ignored, err_ovf set.
- Sticky errors clear only on reset.

## Timing
- Reset (async assert, sync-style deassert per team rule): state IDLE; in_ready 0 while rst low; all other outputs 0; credits OUT_DEPTH; counters 0.
- in_ready is combinational from state and credits only. It never depends on in_valid.
- win_valid, win_row, win_col are registered: asserted exactly 1 cycle after the accepting edge. This aligns with the line-buffer column output.
- frame_done is registered. It is asserted 1 cycle after DRAIN observes inflight == 0, which is ≥ 2 cycles after the final res_done.
- Throughput: 1 pixel/cycle while credits > 0.
- Reset mid-frame: everything returns to the reset state immediately. Results still in the sorter are dropped; the datapath is reset on the same rst.

## Structure
- Shared package median_ctrl_pkg:
  - state enum (IDLE/RUN/DRAIN/DONE)
  - KSIZE = 7, KHALF = 3
  - width helper for coordinates, reused by the 3x3/5x5 variants
- One natural sub-module: median_credit_cnt. It is an up/down saturating counter with simultaneous inc/dec, parameterized init and max, and an overflow/underflow error output. It is instantiated twice, for credits and inflight.

## Test plan
- IMG_W=10, IMG_H=8, OUT_DEPTH=16; continuous valid with sof on the first beat; res_done = win_valid delayed 12 cycles; pop every result.
  - Expect exactly 8 win_valid pulses: first centre (3,3), last (4,6).
  - Expect a single frame_done; busy low afterwards.
- OUT_DEPTH=4, fifo_pop held 0: in_ready falls the cycle after the 4th window pixel is accepted. One pop gives exactly one more window, then in_ready is 0 again.
- credits=1 with a window accept and fifo_pop in the same cycle: credits stay 1 and in_ready stays 1.
- in_sof re-asserted at beat 30: err_sof = 1; that beat is (0,0); the next 8 windows start at centre (3,3).
- rst pulled low in DRAIN with inflight=5: outputs 0 immediately; after release, state IDLE, credits OUT_DEPTH, no frame_done.
- fifo_pop with credits full, and a res_done injected at inflight 0: err_ovf = 1 and counters unchanged.
